// File: rtl/ext_irq_ctrl_pkg.sv
// Shared definitions for the external interrupt controller: register map,
// default bus window and register reset values.
package ext_irq_ctrl_pkg;

  localparam logic [7:0] ADDR_HI_DEFAULT = 8'h04;

  // Word offsets, taken from iomem_addr[7:2]
  typedef enum logic [5:0] {
    REG_ENABLE   = 6'h00,
    REG_PENDING  = 6'h01,
    REG_POLARITY = 6'h02,
    REG_MODE     = 6'h03,
    REG_RAW      = 6'h04
  } reg_off_e;

  localparam logic [7:0] RST_ENABLE   = '0;
  localparam logic [7:0] RST_PENDING  = '0;
  localparam logic [7:0] RST_POLARITY = '1;
  localparam logic [7:0] RST_MODE     = '1;

endpackage

// File: rtl/irq_debounce.sv
// Two-flop synchroniser followed by a stability counter; stable_o changes only
// after the synchronised input has disagreed with it for DEBOUNCE cycles.
module irq_debounce
  import ext_irq_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic pin_i,
  output logic stable_o
);

  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic          sync1_q, sync2_q;
  logic          stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      sync1_q  <= pin_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o = stable_q;

endmodule

// File: rtl/ext_irq_ctrl.sv
// Memory-mapped external interrupt controller: debounced switch inputs, edge or
// level detection, W1C pending latch, enable mask and registered IRQ outputs.
module ext_irq_ctrl
  import ext_irq_ctrl_pkg::*;
#(
  parameter int unsigned N_IRQ    = 3,
  parameter int unsigned DEBOUNCE = 16,
  parameter logic [7:0]  ADDR_HI  = ADDR_HI_DEFAULT
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  output logic [N_IRQ-1:0] irq_out
);

  logic [N_IRQ-1:0] stable;
  logic [N_IRQ-1:0] active;
  logic [N_IRQ-1:0] enable_q, enable_d;
  logic [N_IRQ-1:0] pending_q, pending_d;
  logic [N_IRQ-1:0] polarity_q, polarity_d;
  logic [N_IRQ-1:0] mode_q, mode_d;
  logic [N_IRQ-1:0] act_prev_q;
  logic [N_IRQ-1:0] irq_q;
  logic [N_IRQ-1:0] w1c;
  logic             ready_q;
  logic [31:0]      rdata_q, rdata_d, rd;
  logic             sel, wr;
  reg_off_e         off;
  logic             unused_bus_bits;

  for (genvar g = 0; g < N_IRQ; g++) begin : g_db
    irq_debounce #(.DEBOUNCE(DEBOUNCE)) u_db (
      .clk     (clk),
      .resetn  (resetn),
      .pin_i   (irq_in[g]),
      .stable_o(stable[g])
    );
  end

  assign active = ~(stable ^ polarity_q);
  assign sel    = iomem_valid && !ready_q && (iomem_addr[31:24] == ADDR_HI);
  assign wr     = sel && iomem_wstrb[0];
  assign off    = reg_off_e'(iomem_addr[7:2]);

  assign unused_bus_bits = ^{iomem_addr[23:8], iomem_addr[1:0],
                             iomem_wdata[31:N_IRQ], iomem_wstrb[3:1]};

  always_comb begin
    enable_d   = enable_q;
    polarity_d = polarity_q;
    mode_d     = mode_q;
    w1c        = '0;
    rd         = '0;
    case (off)
      REG_ENABLE: begin
        rd[N_IRQ-1:0] = enable_q;
        if (wr) enable_d = iomem_wdata[N_IRQ-1:0];
      end
      REG_PENDING: begin
        rd[N_IRQ-1:0] = pending_q;
        if (wr) w1c = iomem_wdata[N_IRQ-1:0];
      end
      REG_POLARITY: begin
        rd[N_IRQ-1:0] = polarity_q;
        if (wr) polarity_d = iomem_wdata[N_IRQ-1:0];
      end
      REG_MODE: begin
        rd[N_IRQ-1:0] = mode_q;
        if (wr) mode_d = iomem_wdata[N_IRQ-1:0];
      end
      REG_RAW: rd[N_IRQ-1:0] = stable;
      default: ;
    endcase
    // Edge bits: a new rising edge overrides a same-cycle W1C. Level bits track active.
    pending_d = (mode_q & ((pending_q & ~w1c) | (active & ~act_prev_q)))
              | (~mode_q & active);
    rdata_d   = sel ? rd : '0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      enable_q   <= RST_ENABLE[N_IRQ-1:0];
      pending_q  <= RST_PENDING[N_IRQ-1:0];
      polarity_q <= RST_POLARITY[N_IRQ-1:0];
      mode_q     <= RST_MODE[N_IRQ-1:0];
      act_prev_q <= '0;
      irq_q      <= '0;
      ready_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      enable_q   <= enable_d;
      pending_q  <= pending_d;
      polarity_q <= polarity_d;
      mode_q     <= mode_d;
      act_prev_q <= active;
      irq_q      <= pending_q & enable_q;
      ready_q    <= sel;
      rdata_q    <= rdata_d;
    end
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = rdata_q;
  assign irq_out     = irq_q;

endmodule

// File: tb/tb_ext_irq_ctrl.sv
// Directed and randomised bench for ext_irq_ctrl against a history-based model.
module tb_ext_irq_ctrl;

  localparam int unsigned N   = 3;
  localparam int unsigned D   = 4;
  localparam logic [7:0]  AHI = 8'h04;

  logic          clk;
  logic          resetn;
  logic [N-1:0]  irq_in;
  logic          iomem_valid;
  logic          iomem_ready;
  logic [3:0]    iomem_wstrb;
  logic [31:0]   iomem_addr;
  logic [31:0]   iomem_wdata;
  logic [31:0]   iomem_rdata;
  logic [N-1:0]  irq_out;

  int vectors     = 0;
  int miscompares = 0;

  ext_irq_ctrl #(.N_IRQ(N), .DEBOUNCE(D), .ADDR_HI(AHI)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .irq_in     (irq_in),
    .iomem_valid(iomem_valid),
    .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb),
    .iomem_addr (iomem_addr),
    .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata),
    .irq_out    (irq_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pin history since reset plus register images
  bit [N-1:0] hist[$];
  bit [N-1:0] m_stab, m_act_prev, m_pend, m_en, m_pol, m_mode, m_irq;
  bit         m_ready;
  bit [31:0]  m_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    m_stab = '0; m_act_prev = '0; m_pend = '0; m_en = '0;
    m_pol = '1; m_mode = '1; m_irq = '0; m_ready = 1'b0; m_rdata = '0;
  endtask

  function automatic bit [N-1:0] past(input int unsigned k);
    if (k < hist.size()) return hist[hist.size() - 1 - k];
    return '0;
  endfunction

  task automatic model_edge();
    bit [N-1:0]  act, nxt, w1c, smp;
    bit          sel, wr, flip;
    int unsigned off;
    bit [31:0]   rd;
    act = ~(m_stab ^ m_pol);
    sel = iomem_valid && !m_ready && (iomem_addr[31:24] == AHI);
    wr  = sel && iomem_wstrb[0];
    off = iomem_addr[7:2];
    rd  = '0;
    case (off)
      0: rd[N-1:0] = m_en;
      1: rd[N-1:0] = m_pend;
      2: rd[N-1:0] = m_pol;
      3: rd[N-1:0] = m_mode;
      4: rd[N-1:0] = m_stab;
      default: rd = '0;
    endcase
    w1c = (wr && off == 1) ? iomem_wdata[N-1:0] : '0;
    for (int b = 0; b < N; b++)
      nxt[b] = m_mode[b] ? ((m_pend[b] && !w1c[b]) || (act[b] && !m_act_prev[b])) : act[b];
    m_irq      = m_pend & m_en;
    m_pend     = nxt;
    m_act_prev = act;
    if (wr) begin
      if (off == 0) m_en   = iomem_wdata[N-1:0];
      if (off == 2) m_pol  = iomem_wdata[N-1:0];
      if (off == 3) m_mode = iomem_wdata[N-1:0];
    end
    m_ready = sel;
    m_rdata = sel ? rd : '0;
    hist.push_back(irq_in);
    if (hist.size() > D + 3) void'(hist.pop_front());
    // stable flips once the last D synchronised samples all disagree with it
    for (int b = 0; b < N; b++) begin
      flip = 1'b1;
      for (int unsigned k = 2; k <= D + 1; k++) begin
        smp = past(k);
        if (smp[b] == m_stab[b]) flip = 1'b0;
      end
      if (flip) m_stab[b] = ~m_stab[b];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("ready", {31'b0, iomem_ready}, {31'b0, m_ready});
    chk("irq_out", {29'b0, irq_out}, {29'b0, m_irq});
    if (m_ready) chk("rdata", iomem_rdata, m_rdata);
  endtask

  task automatic bus(input logic [31:0] addr, input logic [3:0] strb,
                     input logic [31:0] wd, output logic [31:0] rd);
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wstrb = strb; iomem_wdata = wd;
    tick();
    rd = iomem_rdata;
    iomem_valid = 1'b0; iomem_wstrb = '0;
    tick();
  endtask

  task automatic rd_reg(input logic [7:0] offs, output logic [31:0] rd);
    bus({AHI, 16'h0, offs}, 4'b0000, 32'h0, rd);
  endtask

  task automatic wr_reg(input logic [7:0] offs, input logic [31:0] wd);
    logic [31:0] rd;
    bus({AHI, 16'h0, offs}, 4'b1111, wd, rd);
  endtask

  initial begin
    logic [31:0] rd;
    logic [7:0]  hi;
    int unsigned idx;
    resetn = 1'b0; irq_in = '0; iomem_valid = 1'b0; iomem_wstrb = '0;
    iomem_addr = '0; iomem_wdata = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'b0, iomem_ready}, 32'h0);
    chk("rst_irq", {29'b0, irq_out}, 32'h0);
    resetn = 1'b1;
    repeat (2) tick();

    rd_reg(8'h00, rd); chk("rst_enable", rd, 32'h0);
    rd_reg(8'h08, rd); chk("rst_polarity", rd, 32'h7);
    rd_reg(8'h0C, rd); chk("rst_mode", rd, 32'h7);

    // rising input to irq_out latency
    wr_reg(8'h00, 32'h1);
    irq_in[0] = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 7) chk("lat_before", {31'b0, irq_out[0]}, 32'h0);
      if (i == 8) chk("lat_at", {31'b0, irq_out[0]}, 32'h1);
    end
    rd_reg(8'h10, rd); chk("raw", rd, 32'h1);
    rd_reg(8'h04, rd); chk("pending_edge", rd, 32'h1);

    wr_reg(8'h04, 32'h1);
    chk("w1c_irq", {31'b0, irq_out[0]}, 32'h0);
    rd_reg(8'h04, rd); chk("w1c_pending", rd, 32'h0);

    // short glitch after the input has settled low
    irq_in[0] = 1'b0;
    repeat (D + 4) tick();
    irq_in[0] = 1'b1;
    repeat (3) tick();
    irq_in[0] = 1'b0;
    repeat (10) tick();
    rd_reg(8'h10, rd); chk("glitch_raw", rd, 32'h0);
    rd_reg(8'h04, rd); chk("glitch_pending", rd, 32'h0);

    // W1C landing on the same edge as a new rising edge
    irq_in[0] = 1'b1; repeat (D + 4) tick();
    irq_in[0] = 1'b0; repeat (D + 4) tick();
    irq_in[0] = 1'b1; repeat (D + 2) tick();
    wr_reg(8'h04, 32'h1);
    rd_reg(8'h04, rd); chk("set_wins", rd, 32'h1);

    // level mode, active-low on bit 1
    wr_reg(8'h0C, 32'h5);
    wr_reg(8'h08, 32'h5);
    wr_reg(8'h00, 32'h3);
    repeat (2) tick();
    chk("level_low_irq", {31'b0, irq_out[1]}, 32'h1);
    wr_reg(8'h04, 32'h2);
    rd_reg(8'h04, rd); chk("level_w1c", {31'b0, rd[1]}, 32'h1);
    irq_in[1] = 1'b1;
    for (int i = 1; i <= D + 4; i++) begin
      tick();
      if (i == D + 3) chk("level_before", {31'b0, irq_out[1]}, 32'h1);
      if (i == D + 4) chk("level_after", {31'b0, irq_out[1]}, 32'h0);
    end

    // enable mask over a pending edge
    wr_reg(8'h00, 32'h0);
    chk("masked_irq", {31'b0, irq_out[0]}, 32'h0);
    rd_reg(8'h04, rd); chk("masked_pending", {31'b0, rd[0]}, 32'h1);
    iomem_valid = 1'b1; iomem_addr = {AHI, 24'h0}; iomem_wstrb = 4'b0001; iomem_wdata = 32'h1;
    tick();
    chk("unmask_same", {31'b0, irq_out[0]}, 32'h0);
    iomem_valid = 1'b0; iomem_wstrb = '0;
    tick();
    chk("unmask_next", {31'b0, irq_out[0]}, 32'h1);

    // bus corner cases
    rd_reg(8'h20, rd); chk("unmapped", rd, 32'h0);
    iomem_valid = 1'b1; iomem_addr = 32'h0300_0000; iomem_wstrb = '0;
    repeat (3) begin
      tick();
      chk("foreign_window", {31'b0, iomem_ready}, 32'h0);
    end
    iomem_addr = {AHI, 24'h0};
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("b2b_ready", {31'b0, iomem_ready}, (i % 2 == 0) ? 32'h1 : 32'h0);
    end
    iomem_valid = 1'b0;
    tick();

    // randomised pins and bus traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        idx = $urandom_range(0, N - 1);
        irq_in[idx] = ~irq_in[idx];
      end
      if ($urandom_range(0, 7) == 0) begin
        hi = ($urandom_range(0, 7) == 0) ? 8'h05 : AHI;
        bus({hi, 16'($urandom), 6'($urandom_range(0, 9)), 2'($urandom)},
            4'($urandom), $urandom, rd);
      end else begin
        tick();
      end
    end

    // asynchronous reset while ready is high
    irq_in = '0;
    iomem_valid = 1'b1; iomem_addr = {AHI, 24'h0}; iomem_wstrb = '0;
    tick();
    #2 resetn = 1'b0;
    model_reset();
    #1;
    chk("async_ready", {31'b0, iomem_ready}, 32'h0);
    chk("async_irq", {29'b0, irq_out}, 32'h0);
    iomem_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    rd_reg(8'h00, rd); chk("re_enable", rd, 32'h0);
    rd_reg(8'h08, rd); chk("re_polarity", rd, 32'h7);
    rd_reg(8'h0C, rd); chk("re_mode", rd, 32'h7);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
